serial_add_arbiter: RTL and testbench
=====================================

# serial_add_arbiter

Sequencer and two-port round-robin arbiter for a bit-serial full-adder datapath. It accepts operand pairs from two requesters over valid/ready handshakes and grants one requester at a time. The granted operands are shifted LSB-first through a single 1-bit full adder with a carry flip-flop, over WIDTH cycles. The block returns the sum, carry-out and requester ID on a result valid/ready port. It sits between the operand producers and the accumulation logic, and is the only owner of the serial adder.

## Interface
- WIDTH, 4, operand/sum width in bits (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid  in  1  requester 1 has operands
- req1_ready  out  1  requester 1 accepted this cycle
- req1_a, req1_b  in  WIDTH  requester 1 operands
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_sum  out  WIDTH  (a+b) mod 2^WIDTH
- res_cout  out  1  carry out of MSB
- res_id  out  1  requester that issued the result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - The grant is computed combinationally from the valids and the last_grant pointer.
  - With only one valid, that requester is granted.
  - With both valid, the requester ≠ last_grant is granted.
  - Only the granted reqN_ready is high; both are low when no request is valid.
- Accept (reqN_valid & reqN_ready):
  - Load shift regs sa←a, sb←b.
  - Clear carry, clear the sum shift reg, record id.
  - Set last_grant←N and go to SHIFT with bit counter = 0.
- SHIFT, one bit per cycle:
  - s = sa[0]^sb[0]^carry.
  - carry ← majority(sa[0], sb[0], carry).
  - sa, sb shift right one bit.
  - s shifts into the sum register MSB side, so after WIDTH cycles bit i sits at res_sum[i].
  - After the counter reaches WIDTH-1, go to DONE.
- DONE:
  - res_valid=1; res_sum, res_cout (final carry) and res_id are held stable.
  - Both reqN_ready are low.
  - On res_ready, go to IDLE.
- Arithmetic: the result is the unsigned WIDTH-bit sum plus the carry. No overflow flag beyond res_cout.
- Reset, including mid-SHIFT or mid-DONE:
  - The in-flight operation is aborted and discarded.
  - state=IDLE, counter=0, carry=0, shift/sum regs=0, res_id=0.
  - last_grant=1, so requester 0 wins the first tie.
  - All outputs are 0: res_valid, busy, res_sum, res_cout, res_id, and both reqN_ready. Readies rise combinationally once rst_n deasserts, if a request is valid.
- Operands are sampled only at the accept edge. Later changes on req*_a/b have no effect.

## Timing
- Accept at edge E0 → SHIFT covers edges E1..E_WIDTH → res_valid is high in the cycle after E_WIDTH (WIDTH cycles after E0).
- Result handshake at edge R → IDLE in the next cycle. The earliest next accept is edge R+1.
- Throughput with res_ready tied high: one operation per WIDTH+2 cycles.
- A result handshake and a new accept never occur in the same cycle.
- res_valid stays high, with stable data, for as long as res_ready is low (backpressure, no loss).
- A requester that holds valid while the other is served is granted at the next IDLE.
- Continuous requests from both sides strictly alternate: 0,1,0,1…

## Test plan
- Single op, WIDTH=4, req0 with a=4'h7, b=4'h9, res_ready=1:
  - res_valid rises 4 cycles after accept.
  - res_sum=4'h0, res_cout=1, res_id=0.
- Max case, a=4'hF, b=4'hF on req1: res_sum=4'hE, res_cout=1, res_id=1. The zero case 0+0 gives sum 0, cout 0.
- Tie after reset:
  - Both valid continuously, req0 (3+4), req1 (5+6).
  - Results in order: id0 sum 4'h7 cout 0, then id1 sum 4'hB cout 0, then id0 again. Readies are never high together.
- Backpressure: hold res_ready=0 for 10 cycles in DONE → res_valid and data stay stable, both readies stay 0, and exactly one result is delivered on release.
- Reset mid-SHIFT: assert rst_n=0 two cycles after accept → all outputs 0 immediately, no result emitted, and the next tie grants req0.
- Randomized operands and valids against a+b golden model, with scoreboard per res_id.

Source files
------------

// File: rtl/serial_add_arbiter_if.sv
// Handshake bundle between the two operand requesters, the result consumer and the serial adder.
// The master modport is the producer/consumer side; the slave modport is the arbiter itself.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id,
        output busy
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Two-port round-robin arbiter in front of a single bit-serial full adder.
// Granted operands shift LSB-first through the adder over WIDTH cycles; result is held until taken.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation in flight; grant offered combinationally
// SHIFT | one operand bit pair added per cycle, carry in a flop
// DONE  | result presented on res_*, waiting for res_ready
module serial_add_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_add_arbiter_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             last_grant;
    logic             grant_id;
    logic             accept;
    logic             ready0;
    logic             ready1;
    logic             res_valid;
    logic             busy;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             id;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             bit_s;
    logic             bit_c;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // With both requesters pending, the one not served last time wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    assign op_a  = grant_id ? bus.req1_a : bus.req0_a;
    assign op_b  = grant_id ? bus.req1_b : bus.req0_b;

    assign bit_s = sa[0] ^ sb[0] ^ carry;
    assign bit_c = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        accept    = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // rst_n gating keeps the readies low while reset is still held.
                if (rst_n) begin
                    ready0 = bus.req0_valid & ~grant_id;
                    ready1 = bus.req1_valid &  grant_id;
                end
                accept = ready0 | ready1;
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            sum        <= '0;
            carry      <= 1'b0;
            id         <= 1'b0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            sa         <= op_a;
            sb         <= op_b;
            sum        <= '0;
            carry      <= 1'b0;
            id         <= grant_id;
            cnt        <= '0;
            last_grant <= grant_id;
        end else if (state == SHIFT) begin
            sa    <= {1'b0, sa[WIDTH-1:1]};
            sb    <= {1'b0, sb[WIDTH-1:1]};
            // Sum bits enter at the MSB so bit i lands at position i after WIDTH shifts.
            sum   <= {bit_s, sum[WIDTH-1:1]};
            carry <= bit_c;
            cnt   <= last_bit ? '0 : cnt + CW'(1);
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = res_valid;
    assign bus.res_sum    = sum;
    assign bus.res_cout   = carry;
    assign bus.res_id     = id;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed and randomized bench for serial_add_arbiter with WIDTH=4.
// Expected results are hand-computed constants or an a+b golden model with per-requester queues.
module tb_serial_add_arbiter;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    serial_add_arbiter_if #(.WIDTH(W)) bus ();

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int             lat;
    int             nres;
    int             res_cyc [3];
    logic [W-1:0]   res_s   [3];
    logic           res_c   [3];
    logic           res_i   [3];
    bit             both_hi;
    bit             bp_bad;
    logic [W-1:0]   s_sum;
    logic           s_cout;
    logic           s_id;

    logic [W-1:0]   a0, b0, a1, b1;
    bit             acc0, acc1, take;
    logic [W-1:0]   t_sum;
    logic           t_cout;
    logic           t_id;
    logic [W:0]     q0 [$];
    logic [W:0]     q1 [$];
    logic [W:0]     exp_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_ready0"}, bus.req0_ready, 0);
        check({tag, "_ready1"}, bus.req1_ready, 0);
        check({tag, "_sum"}, bus.res_sum, 0);
        check({tag, "_cout"}, bus.res_cout, 0);
        check({tag, "_id"}, bus.res_id, 0);
    endtask

    // Counts cycles from the accept edge until res_valid is seen; gives up at 50.
    task automatic wait_res(output int cycles);
        cycles = 0;
        while (!bus.res_valid && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic single_op(input logic rq, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] es, input logic ec, input string tag);
        int l;
        if (rq) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
        #1;
        check({tag, "_ready_granted"}, rq ? bus.req1_ready : bus.req0_ready, 1);
        check({tag, "_ready_other"}, rq ? bus.req0_ready : bus.req1_ready, 0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        wait_res(l);
        check({tag, "_latency"}, l, W);
        check({tag, "_sum"}, bus.res_sum, es);
        check({tag, "_cout"}, bus.res_cout, ec);
        check({tag, "_id"}, bus.res_id, rq);
        @(posedge clk); #1;
        check({tag, "_res_dropped"}, bus.res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_a     = 4'h3;
        bus.req0_b     = 4'h4;
        bus.req1_a     = 4'h5;
        bus.req1_b     = 4'h6;
        bus.res_ready  = 1'b1;

        // Reset state with requests pending: everything must stay low.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        #1;

        single_op(1'b0, 4'h7, 4'h9, 4'h0, 1'b1, "op_7_9");
        single_op(1'b1, 4'hF, 4'hF, 4'hE, 1'b1, "op_f_f");
        single_op(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "op_0_0");

        // Tie after reset: strict alternation starting with requester 0.
        apply_reset();
        bus.req0_a = 4'h3; bus.req0_b = 4'h4; bus.req0_valid = 1'b1;
        bus.req1_a = 4'h5; bus.req1_b = 4'h6; bus.req1_valid = 1'b1;
        bus.res_ready = 1'b1;
        nres    = 0;
        both_hi = 1'b0;
        #1;
        check("tie_first_ready0", bus.req0_ready, 1);
        for (int c = 0; c < 40 && nres < 3; c++) begin
            @(posedge clk); #1;
            if (bus.req0_ready && bus.req1_ready) both_hi = 1'b1;
            if (bus.res_valid) begin
                res_cyc[nres] = c;
                res_s[nres]   = bus.res_sum;
                res_c[nres]   = bus.res_cout;
                res_i[nres]   = bus.res_id;
                nres++;
                if (nres == 3) begin
                    bus.req0_valid = 1'b0;
                    bus.req1_valid = 1'b0;
                end
            end
        end
        check("tie_nres", nres, 3);
        check("tie_both_ready", both_hi, 0);
        check("tie_r0", {res_i[0], res_c[0], res_s[0]}, {1'b0, 1'b0, 4'h7});
        check("tie_r1", {res_i[1], res_c[1], res_s[1]}, {1'b1, 1'b0, 4'hB});
        check("tie_r2", {res_i[2], res_c[2], res_s[2]}, {1'b0, 1'b0, 4'h7});
        check("tie_first_latency", res_cyc[0], W);
        check("tie_throughput", res_cyc[1] - res_cyc[0], W + 2);
        @(posedge clk); #1;
        check("tie_idle", bus.busy, 0);

        // Backpressure: req1 wins (last grant was 0), req0 waits behind it.
        bus.res_ready  = 1'b0;
        bus.req1_a = 4'hF; bus.req1_b = 4'hF; bus.req1_valid = 1'b1;
        bus.req0_a = 4'h0; bus.req0_b = 4'h0; bus.req0_valid = 1'b1;
        #1;
        check("bp_ready1", bus.req1_ready, 1);
        check("bp_ready0", bus.req0_ready, 0);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_res(lat);
        check("bp_latency", lat, W);
        s_sum  = bus.res_sum;
        s_cout = bus.res_cout;
        s_id   = bus.res_id;
        check("bp_result", {s_id, s_cout, s_sum}, {1'b1, 1'b1, 4'hE});
        bp_bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!bus.res_valid || bus.res_sum !== s_sum || bus.res_cout !== s_cout ||
                bus.res_id !== s_id || bus.req0_ready || bus.req1_ready) bp_bad = 1'b1;
        end
        check("bp_stable", bp_bad, 0);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_single_delivery", bus.res_valid, 0);
        check("bp_waiter_ready0", bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_res(lat);
        check("zero_latency", lat, W);
        check("zero_result", {bus.res_id, bus.res_cout, bus.res_sum}, {1'b0, 1'b0, 4'h0});
        @(posedge clk); #1;

        // Reset two cycles into SHIFT of a req0 operation.
        bus.req0_a = 4'h5; bus.req0_b = 4'h6; bus.req0_valid = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_before", bus.busy, 1);
        bus.req0_a = 4'h9; bus.req0_b = 4'h8; bus.req0_valid = 1'b1;
        bus.req1_a = 4'h2; bus.req1_b = 4'h2; bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mid_tie_ready0", bus.req0_ready, 1);
        check("mid_tie_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_res(lat);
        check("mid_latency", lat, W);
        check("mid_result", {bus.res_id, bus.res_cout, bus.res_sum}, {1'b0, 1'b1, 4'h1});
        @(posedge clk); #1;

        // Randomized traffic against the a+b model.
        a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
        a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
        both_hi = 1'b0;
        for (int c = 0; c < 500; c++) begin
            bus.req0_a = a0; bus.req0_b = b0;
            bus.req1_a = a1; bus.req1_b = b1;
            #1;
            acc0   = bus.req0_valid && bus.req0_ready;
            acc1   = bus.req1_valid && bus.req1_ready;
            take   = bus.res_valid && bus.res_ready;
            t_sum  = bus.res_sum;
            t_cout = bus.res_cout;
            t_id   = bus.res_id;
            if (bus.req0_ready && bus.req1_ready) both_hi = 1'b1;
            @(posedge clk); #1;
            if (acc0) q0.push_back({1'b0, a0} + {1'b0, b0});
            if (acc1) q1.push_back({1'b0, a1} + {1'b0, b1});
            if (take) begin
                check("rand_expected_pending", (t_id ? q1.size() : q0.size()) != 0, 1);
                if (t_id && q1.size() != 0) begin
                    exp_r = q1.pop_front();
                    check("rand_res_id1", {t_cout, t_sum}, exp_r);
                end else if (!t_id && q0.size() != 0) begin
                    exp_r = q0.pop_front();
                    check("rand_res_id0", {t_cout, t_sum}, exp_r);
                end
            end
            if (c < 470) begin
                if (acc0 || !bus.req0_valid) begin
                    bus.req0_valid = 1'($urandom_range(0, 1));
                    a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
                end
                if (acc1 || !bus.req1_valid) begin
                    bus.req1_valid = 1'($urandom_range(0, 1));
                    a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
                end
                bus.res_ready = ($urandom_range(0, 3) != 0);
            end else begin
                if (acc0) bus.req0_valid = 1'b0;
                if (acc1) bus.req1_valid = 1'b0;
                bus.res_ready = 1'b1;
            end
        end
        check("rand_both_ready", both_hi, 0);
        check("rand_q0_drained", q0.size(), 0);
        check("rand_q1_drained", q1.size(), 0);
        check("rand_final_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
